// File: rtl/rsa_pkg.sv
// Shared defaults, FSM encoding and iteration sizing for the Montgomery reduction datapath.
// Pure declarations; no latency or flow control of its own.
package rsa_pkg;

  localparam int N_BITS_DFLT = 1024;
  localparam int W_DFLT      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RED  = 2'd1,
    FIN  = 2'd2
  } red_state_e;

  function automatic int calc_iter(input int n_bits, input int w);
    return n_bits / w;
  endfunction

  // A single-iteration configuration still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int n_bits, input int w);
    int it;
    it = n_bits / w;
    return (it > 1) ? $clog2(it) : 1;
  endfunction

endpackage

// File: rtl/mont_word_step.sv
// One Montgomery word step: acc_nxt = (acc + m*n_q) >> W with m = acc[W-1:0]*n0p_q mod 2^W.
// Purely combinational; no backpressure.
module mont_word_step
  import rsa_pkg::*;
#(
  parameter int N_BITS = N_BITS_DFLT,
  parameter int W      = W_DFLT
) (
  input  logic [2*N_BITS:0]  acc,
  input  logic [N_BITS-1:0]  n_q,
  input  logic [W-1:0]       n0p_q,
  output logic [2*N_BITS:0]  acc_nxt
);

  logic [W-1:0]        m;
  logic [N_BITS+W-1:0] mn;
  logic [2*N_BITS:0]   sum;

  // The low W bits of sum are zero by choice of m, so the shift drops no information.
  always_comb begin
    m       = acc[W-1:0] * n0p_q;
    mn      = {{N_BITS{1'b0}}, m} * {{W{1'b0}}, n_q};
    sum     = acc + {{(N_BITS+1-W){1'b0}}, mn};
    acc_nxt = sum >> W;
  end

endmodule

// File: rtl/mont_redc_serial.sv
// Word-serial Montgomery reduction result = T * 2^-N_BITS mod n; done pulses ITER+1 cycles after start.
// start is only sampled in IDLE; requests while busy (including FIN) are dropped, never queued.
module mont_redc_serial
  import rsa_pkg::*;
#(
  parameter int N_BITS = N_BITS_DFLT,
  parameter int W      = W_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*N_BITS-1:0]   t_in,
  input  logic [N_BITS-1:0]     n,
  input  logic [W-1:0]          n0prime,
  output logic                  busy,
  output logic                  done,
  output logic [N_BITS-1:0]     result
);

  localparam int ITER  = calc_iter(N_BITS, W);
  localparam int CNT_W = calc_cnt_w(N_BITS, W);

  red_state_e          state_q, state_d;
  logic [2*N_BITS:0]   acc_q, acc_d, acc_step;
  logic [N_BITS-1:0]   n_q, n_d;
  logic [W-1:0]        n0p_q, n0p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [N_BITS-1:0]   result_q, result_d;

  mont_word_step #(
    .N_BITS (N_BITS),
    .W      (W)
  ) u_step (
    .acc     (acc_q),
    .n_q     (n_q),
    .n0p_q   (n0p_q),
    .acc_nxt (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    n_d      = n_q;
    n0p_d    = n0p_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {{(N_BITS+1){1'b0}}, t_in};
          n_d     = n;
          n0p_d   = n0prime;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RED;
        end
      end
      RED: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER-1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // acc < 2n here, so one conditional subtract lands in [0, n); low bits suffice.
        if (acc_q >= {{(N_BITS+1){1'b0}}, n_q}) begin
          result_d = acc_q[N_BITS-1:0] - n_q;
        end else begin
          result_d = acc_q[N_BITS-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      n_q      <= '0;
      n0p_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      n_q      <= n_d;
      n0p_q    <= n0p_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mont_redc_serial.sv
// Directed and randomized checks of mont_redc_serial against an independent bignum construction.
module tb_mont_redc_serial;
  localparam int NB   = 1024;
  localparam int WW   = 32;
  localparam int ITER = NB / WW;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [2*NB-1:0]   t_in;
  logic [NB-1:0]     n;
  logic [WW-1:0]     n0prime;
  logic              busy;
  logic              done;
  logic [NB-1:0]     result;

  typedef struct {
    logic [NB-1:0] res;
    int            acc_cyc;
  } job_t;

  job_t sb[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   n_done = 0;

  mont_redc_serial #(.N_BITS(NB), .W(WW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .t_in    (t_in),
    .n       (n),
    .n0prime (n0prime),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed(low192)=%0h expected(low192)=%0h", tag, obs[191:0], exp[191:0]);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest outstanding job.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", NB'(done), '0);
      end else begin
        job_t j;
        j = sb.pop_front();
        check("result", result, j.res);
        check("latency", NB'(cyc - j.acc_cyc), NB'(ITER + 1));
      end
    end
  end

  function automatic logic [NB-1:0] rnd();
    logic [NB-1:0] r;
    for (int i = 0; i < NB / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [WW-1:0] calc_n0p(input logic [NB-1:0] nn);
    logic [WW-1:0] x;
    x = nn[WW-1:0];
    repeat (5) x = x * (32'd2 - nn[WW-1:0] * x);
    return -x;
  endfunction

  // Builds T = (y*R + k*n) mod (n*R), so T < n*R and T*R^-1 mod n == y.
  task automatic rand_job(output logic [2*NB-1:0] t, output logic [NB-1:0] nn,
                          output logic [WW-1:0] n0p, output logic [NB-1:0] y);
    logic [3*NB-1:0] ye, ke, ne, big;
    nn = rnd();
    nn[0] = 1'b1;
    y  = rnd() % nn;
    ye = {{(2*NB){1'b0}}, y};
    ke = {{(2*NB){1'b0}}, rnd()};
    ne = {{(2*NB){1'b0}}, nn};
    big = ((ye << NB) + ke * ne) % (ne << NB);
    t   = (2*NB)'(big);
    n0p = calc_n0p(nn);
  endtask

  task automatic launch(input logic [2*NB-1:0] t, input logic [NB-1:0] nn,
                        input logic [WW-1:0] n0p, input logic [NB-1:0] exp);
    job_t j;
    @(negedge clk);
    t_in    = t;
    n       = nn;
    n0prime = n0p;
    start   = 1'b1;
    j.res     = exp;
    j.acc_cyc = cyc + 1;
    sb.push_back(j);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", NB'(sb.size()), '0);
    sb.delete();
  endtask

  initial begin
    logic [NB-1:0]   nmax, nm1, nn, y, y2;
    logic [2*NB-1:0] t, t2;
    logic [WW-1:0]   n0p, n0p2;
    job_t            j;
    int              bc, d0;

    rst_n = 1'b0; start = 1'b0; t_in = '0; n = '0; n0prime = '0;
    #1;
    check("rst_busy", NB'(busy), '0);
    check("rst_done", NB'(done), '0);
    check("rst_result", result, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed: n = 2^1024-1, n0prime = 1; also busy duration
    nmax = '1;
    nm1  = nmax - 1'b1;
    launch({{(NB-8){1'b0}}, 8'h5A, {NB{1'b0}}}, nmax, 32'd1, NB'(8'h5A));
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    check("busy_cycles", NB'(bc), NB'(ITER + 1));
    drain();
    launch({{NB{1'b0}}, nmax}, nmax, 32'd1, '0);        // acc == n in FIN
    drain();
    launch({nm1, {NB{1'b0}}}, nmax, 32'd1, nm1);
    drain();
    launch('0, nmax, 32'd1, '0);
    drain();

    // Random jobs
    for (int i = 0; i < 500; i++) begin
      rand_job(t, nn, n0p, y);
      launch(t, nn, n0p, y);
      drain();
    end

    // start held high through a job, into FIN and the done cycle
    rand_job(t, nn, n0p, y);
    rand_job(t2, nn, n0p2, y2);
    rand_job(t, nn, n0p, y);
    d0 = n_done;
    @(negedge clk);
    t_in = t; n = nn; n0prime = n0p; start = 1'b1;
    j.res = y; j.acc_cyc = cyc + 1;
    sb.push_back(j);
    @(negedge clk);
    rand_job(t2, nn, n0p2, y2);
    t_in = t2; n = nn; n0prime = n0p2;
    repeat (33) @(negedge clk);
    j.res = y2; j.acc_cyc = cyc + 1;
    sb.push_back(j);
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("done_count_held_start", NB'(n_done - d0), NB'(2));

    // Inputs changed mid-job must not matter
    rand_job(t, nn, n0p, y);
    launch(t, nn, n0p, y);
    repeat (3) @(negedge clk);
    rand_job(t2, nn, n0p2, y2);
    t_in = t2; n = nn; n0prime = n0p2;
    drain();

    // Async reset in RED cycle 10
    rand_job(t, nn, n0p, y);
    launch(t, nn, n0p, y);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", NB'(busy), '0);
    check("arst_done", NB'(done), '0);
    check("arst_result", result, '0);
    sb.delete();
    d0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("no_done_after_abort", NB'(n_done - d0), '0);
    rand_job(t, nn, n0p, y);
    launch(t, nn, n0p, y);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mont_redc_serial.md
Name: mont_redc_serial

Overview:
- Word-serial Montgomery reduction: computes result = T * R^-1 mod n, with R = 2^N_BITS.
- Consumer of the n0prime value (n0prime = -n^-1 mod 2^W) that the RSA decryption datapath precomputes.
- Sits between the modular-multiply/square datapath and the exponentiation controller; every product T is reduced here.

Parameters:
- N_BITS, 1024, modulus width; must be a multiple of W.
- W, 32, word width; also the width of n0prime.
- ITER, N_BITS/W, number of reduction iterations (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- t_in  input  2*N_BITS  value to reduce; precondition t_in < n*R.
- n  input  N_BITS  odd modulus.
- n0prime  input  W  -n^-1 mod 2^W.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result is valid in the same cycle.
- result  output  N_BITS  reduced value, always < n; held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, accumulator=0, counter=0.
- Reset mid-operation aborts the reduction immediately; no done pulse is produced.
- Internal registers:
  - acc: 2*N_BITS+1 bits, the extra bit holds the carry of acc + m*n.
  - n_q: N_BITS, n0p_q: W, cnt: clog2(ITER) bits.
- States:
  - IDLE:
    - done=0.
    - On start=1: acc <= t_in (zero-extended), n_q <= n, n0p_q <= n0prime, cnt <= 0, busy <= 1, go to RED.
    - Inputs are captured at acceptance only; later changes to n/n0prime/t_in have no effect.
  - RED (one iteration per cycle):
    - m = (acc[W-1:0] * n0p_q) mod 2^W.
    - acc <= (acc + m*n_q) >> W. The low W bits of the sum are zero by construction.
    - cnt <= cnt+1.
    - When cnt == ITER-1, go to FIN.
  - FIN:
    - If acc >= n_q: result <= acc - n_q; else result <= acc[N_BITS-1:0].
    - done <= 1, busy <= 0, go to IDLE.
- Latency:
  - start sampled on edge E0.
  - RED occupies edges E1..E_ITER; FIN registers on edge E_(ITER+1).
  - done is high for exactly the cycle following E_(ITER+1), i.e. ITER+1 cycles after acceptance (33 at the defaults).
- Width rules:
  - acc + m*n_q never exceeds 2*N_BITS+1 bits.
  - Before the final subtract, acc < 2n given the t_in precondition.
  - A single conditional subtract is sufficient.
- Boundary conditions:
  - start while busy, including in FIN: ignored, no queuing.
  - start in the cycle done is high (state already IDLE): accepted. done still pulses only once for the prior job.
  - t_in = 0: result = 0.
  - acc == n_q exactly in FIN: the subtract branch is taken and result = 0.
  - Violating the precondition (even n, or t_in >= n*R) gives an undefined result, but ITER+1 latency and the single done pulse are still guaranteed.

Decomposition:
- Shared package rsa_pkg holds:
  - N_BITS and W defaults;
  - state encoding IDLE/RED/FIN;
  - a helper function computing ITER and the counter width.
- Sub-module mont_word_step (combinational, one W x N_BITS multiply-accumulate plus shift):
  - inputs acc, n_q, n0p_q; output next acc;
  - instantiated once;
  - lets a later multi-cycle or pipelined step replace it without touching the FSM.

Test Plan:
1. N_BITS=1024, W=32, n=2^1024-1, n0prime=1, t_in=0x5A<<1024 -> result=0x5A, done exactly 33 cycles after the start edge, busy high for 33 cycles.
2. Same n/n0prime, t_in=n -> result=0. Also t_in=(n-1)<<1024 -> result=n-1.
3. Randomized coverage:
   - 500 jobs with random odd n, n0prime from the bench model, and t_in < n*R.
   - Compare each result against a bignum model.
   - Coverage: both FIN branches hit, including a directed acc==n case giving 0.
4. Assert start every cycle during a job:
   - exactly one done per accepted job, the second start ignored;
   - start in the done cycle launches the next job, whose done arrives 33 cycles later.
5. Drop rst_n low at RED cycle 10 -> busy, done and result go to 0 immediately (asynchronously) and no done follows. A fresh start after release completes correctly.
6. Change n, n0prime and t_in mid-job -> result matches the values captured at acceptance.
